// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite types and bus widths.
// Latency: none (declarations only).
// Backpressure: n/a.
package axi_lite_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Word offset of a byte address relative to a base; callers truncate to their depth.
    function automatic logic [ADDR_W-1:0] word_offset(input logic [ADDR_W-1:0] addr,
                                                      input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] diff;
        diff = addr - base;
        return diff >> 2;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bus bundle with master and slave views.
// Latency: none (wires only).
// Backpressure: carried by the valid/ready pairs of each channel.
interface axi_lite_if;
    import axi_lite_pkg::*;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/ram_1rw.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Latency: read data appears one cycle after an enabled access.
// Backpressure: none; rdata holds its last value while en is low.
module ram_1rw
    import axi_lite_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [STRB_W-1:0] we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane writes and read-before-write output register.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI-lite slave in front of a word RAM, one transaction at a time; optional range check via AXI_RAM_ERR_EN.
// Latency: response valid LATENCY+1 cycles after address (and write data) capture.
// Backpressure: R/B held stable until rready/bready; no new request accepted until then.
module axi_lite_ram_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned       LATENCY   = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    axi_lite_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP
    } state_t;

    state_t            state_q;
    logic              ar_rdy_q, aw_rdy_q, w_rdy_q;
    logic              rvalid_q, bvalid_q;
    resp_t             rresp_q, bresp_q;
    logic [3:0]        cnt_q;
    logic [AW-1:0]     idx_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              aw_rdy, w_rdy;
    logic              ar_hs, aw_hs, w_hs;
    logic              ar_err, aw_err;
    logic              wait_done;
    logic              ram_en;
    logic [STRB_W-1:0] ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // A pending read in IDLE wins: the write readies are masked in that same cycle.
    assign aw_rdy = aw_rdy_q & ~(ar_rdy_q & bus.arvalid);
    assign w_rdy  = w_rdy_q  & ~(ar_rdy_q & bus.arvalid);
    assign ar_hs  = ar_rdy_q & bus.arvalid;
    assign aw_hs  = aw_rdy   & bus.awvalid;
    assign w_hs   = w_rdy    & bus.wvalid;

`ifdef AXI_RAM_ERR_EN
    assign ar_err = {32'b0, bus.araddr - BASE_ADDR} >= (64'(DEPTH) << 2);
    assign aw_err = {32'b0, bus.awaddr - BASE_ADDR} >= (64'(DEPTH) << 2);
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    // The RAM is touched only on the last wait cycle; its read register then lines up with rvalid.
    assign wait_done = (cnt_q == 4'd0);
    assign ram_en    = ((state_q == RD_WAIT) || (state_q == WR_WAIT)) && wait_done;
    assign ram_we    = (state_q == WR_WAIT && wait_done && !err_q) ? wstrb_q : '0;

    ram_1rw #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.arready = ar_rdy_q;
    assign bus.awready = aw_rdy;
    assign bus.wready  = w_rdy;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = (rvalid_q && !err_q) ? ram_rdata : '0;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;

    // Transaction sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ar_rdy_q <= 1'b0;
            aw_rdy_q <= 1'b0;
            w_rdy_q  <= 1'b0;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            bresp_q  <= OKAY;
            cnt_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ar_rdy_q <= 1'b1;
                    aw_rdy_q <= 1'b1;
                    w_rdy_q  <= 1'b1;
                    if (ar_hs) begin
                        idx_q    <= AW'(word_offset(bus.araddr, BASE_ADDR));
                        err_q    <= ar_err;
                        cnt_q    <= 4'(LATENCY);
                        ar_rdy_q <= 1'b0;
                        aw_rdy_q <= 1'b0;
                        w_rdy_q  <= 1'b0;
                        state_q  <= RD_WAIT;
                    end else if (aw_hs || w_hs) begin
                        if (aw_hs) begin
                            idx_q <= AW'(word_offset(bus.awaddr, BASE_ADDR));
                            err_q <= aw_err;
                        end
                        if (w_hs) begin
                            wdata_q <= bus.wdata;
                            wstrb_q <= bus.wstrb;
                        end
                        ar_rdy_q <= 1'b0;
                        aw_rdy_q <= !aw_hs;
                        w_rdy_q  <= !w_hs;
                        cnt_q    <= 4'(LATENCY);
                        state_q  <= (aw_hs && w_hs) ? WR_WAIT : WR_COLLECT;
                    end
                end
                WR_COLLECT: begin
                    // Only the missing channel's ready is still up, so any handshake completes the pair.
                    if (aw_hs) begin
                        idx_q <= AW'(word_offset(bus.awaddr, BASE_ADDR));
                        err_q <= aw_err;
                    end
                    if (w_hs) begin
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                    end
                    if (aw_hs || w_hs) begin
                        aw_rdy_q <= 1'b0;
                        w_rdy_q  <= 1'b0;
                        cnt_q    <= 4'(LATENCY);
                        state_q  <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_done) begin
                        rvalid_q <= 1'b1;
                        rresp_q  <= err_q ? SLVERR : OKAY;
                        state_q  <= RD_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RD_RESP: begin
                    if (bus.rready) begin
                        rvalid_q <= 1'b0;
                        rresp_q  <= OKAY;
                        ar_rdy_q <= 1'b1;
                        aw_rdy_q <= 1'b1;
                        w_rdy_q  <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (wait_done) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= err_q ? SLVERR : OKAY;
                        state_q  <= WR_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_RESP: begin
                    if (bus.bready) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= OKAY;
                        ar_rdy_q <= 1'b1;
                        aw_rdy_q <= 1'b1;
                        w_rdy_q  <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Self-checking bench for axi_lite_ram_slave against a word-array reference model.
// Latency: checks read response timing of LATENCY+1 cycles.
// Backpressure: exercises held rready and AR-over-AW/W priority.
module tb_axi_lite_ram_slave;
    import axi_lite_pkg::*;

    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned LAT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] model [int];

    axi_lite_if bus ();

    axi_lite_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic bit addr_err(input logic [31:0] a);
`ifdef AXI_RAM_ERR_EN
        return (a < BASE) || ((64'(a) - 64'(BASE)) >= 64'(4 * DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) / 4) % DEPTH);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        int i;
        if (addr_err(a)) return;
        i = widx(a);
        w = model.exists(i) ? model[i] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model[i] = w;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (addr_err(a)) return 32'h0;
        return model.exists(widx(a)) ? model[widx(a)] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return addr_err(a) ? 2'b10 : 2'b00;
    endfunction

    // ---------------- bus drivers (called at a falling edge) ----------------
    task automatic send_ar(input logic [31:0] a, output bit to);
        int n = 0;
        to = 1'b0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        #1;
        while (!bus.arready) begin
            @(negedge clk); #1;
            n++;
            if (n > 100) begin to = 1'b1; break; end
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] r, output int lat, output bit to);
        to  = 1'b0;
        lat = 0;
        while (!bus.rvalid) begin
            @(negedge clk);
            lat++;
            if (lat > 100) begin to = 1'b1; break; end
        end
        d = bus.rdata;
        r = bus.rresp;
    endtask

    task automatic take_r();
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                           output int lat, output bit to);
        bit t1, t2;
        send_ar(a, t1);
        wait_r(d, r, lat, t2);
        take_r();
        to = t1 | t2;
    endtask

    task automatic wait_b(output logic [1:0] r, output bit to);
        int n = 0;
        to = 1'b0;
        while (!bus.bvalid) begin
            @(negedge clk);
            n++;
            if (n > 100) begin to = 1'b1; break; end
        end
        r = bus.bresp;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output bit to);
        bit aw_done = 1'b0, w_done = 1'b0, tb;
        int n = 0;
        to = 1'b0;
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata  = d; bus.wstrb   = s; bus.wvalid = 1'b1;
        while (!(aw_done && w_done)) begin
            #1;
            if (bus.awvalid && bus.awready) aw_done = 1'b1;
            if (bus.wvalid && bus.wready)   w_done  = 1'b1;
            @(negedge clk);
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done)  bus.wvalid  = 1'b0;
            n++;
            if (n > 100) begin to = 1'b1; break; end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        wait_b(r, tb);
        to = to | tb;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0; bus.rready = 0; bus.bready = 0;
        bus.araddr = 0; bus.awaddr = 0; bus.wdata = 0; bus.wstrb = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_handshakes: got %b want 00000",
                     {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
        end
        n_checks++;
        if ({bus.rdata, bus.rresp, bus.bresp} !== 36'h0) begin
            n_errors++;
            $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b want 0", bus.rdata, bus.rresp, bus.bresp);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin
            n_errors++;
            $display("FAIL idle_readies: got %b want 111", {bus.arready, bus.awready, bus.wready});
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic [1:0] r; int lat; bit to;
        do_write(32'h10, 32'hDEADBEEF, 4'hF, r, to);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        n_checks++;
        if (to || r !== 2'b00) begin n_errors++; $display("FAIL wr_bresp: got %b to=%0d want 00", r, to); end
        do_read(32'h10, d, r, lat, to);
        n_checks++;
        if (to || d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_data: got %h want deadbeef", d); end
        n_checks++;
        if (r !== 2'b00) begin n_errors++; $display("FAIL rd_rresp: got %b want 00", r); end
        n_checks++;
        if (lat !== LAT + 1) begin n_errors++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT + 1); end
        n_checks++;
        if (bus.rdata !== 32'h0) begin n_errors++; $display("FAIL rdata_cleared: got %h want 0", bus.rdata); end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] d; logic [1:0] r; int lat; bit to;
        do_write(32'h20, 32'h11223344, 4'hF, r, to);
        model_write(32'h20, 32'h11223344, 4'hF);
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, r, to);
        model_write(32'h20, 32'hAABBCCDD, 4'b0101);
        n_checks++;
        if (to || r !== 2'b00) begin n_errors++; $display("FAIL strb_bresp: got %b want 00", r); end
        do_read(32'h20, d, r, lat, to);
        n_checks++;
        if (to || d !== 32'h11BB33DD) begin n_errors++; $display("FAIL strb_data: got %h want 11bb33dd", d); end
    endtask

    task automatic test_split_aw_w();
        logic [31:0] wd, d; logic [1:0] r; int lat, nb; bit to;
        wd = $urandom;
        bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        #1;
        n_checks++;
        if (bus.wready !== 1'b1) begin n_errors++; $display("FAIL split_wready_idle: got %b want 1", bus.wready); end
        @(negedge clk);
        bus.wvalid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if ({bus.wready, bus.awready, bus.arready} !== 3'b010) begin
                n_errors++;
                $display("FAIL split_readies_c%0d: w/aw/ar=%b want 010", k, {bus.wready, bus.awready, bus.arready});
            end
            if (k < 3) @(negedge clk);
        end
        bus.awaddr = 32'h40; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        model_write(32'h40, wd, 4'hF);
        bus.bready = 1'b1;
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.bvalid) nb++;
            @(negedge clk);
        end
        bus.bready = 1'b0;
        n_checks++;
        if (nb !== 1) begin n_errors++; $display("FAIL split_b_count: got %0d want 1", nb); end
        do_read(32'h40, d, r, lat, to);
        n_checks++;
        if (to || d !== model_read(32'h40)) begin n_errors++; $display("FAIL split_data: got %h want %h", d, model_read(32'h40)); end
    endtask

    task automatic test_ar_priority();
        logic [31:0] wd, d; logic [1:0] r; int lat, viol, n; bit to;
        wd = $urandom;
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        bus.awaddr = 32'h30; bus.awvalid = 1'b1;
        bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        #1;
        n_checks++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b100) begin
            n_errors++;
            $display("FAIL prio_readies: ar/aw/w=%b want 100", {bus.arready, bus.awready, bus.wready});
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        viol = 0; n = 0;
        while (!bus.rvalid && n <= 100) begin
            if (bus.awready || bus.wready || bus.bvalid) viol++;
            @(negedge clk);
            n++;
        end
        if (bus.awready || bus.wready) viol++;
        n_checks++;
        if (viol !== 0 || n > 100) begin n_errors++; $display("FAIL prio_write_blocked: violations=%0d cycles=%0d want 0", viol, n); end
        n_checks++;
        if (bus.rdata !== model_read(32'h10)) begin n_errors++; $display("FAIL prio_rdata: got %h want %h", bus.rdata, model_read(32'h10)); end
        take_r();
        n_checks++;
        if ({bus.awready, bus.wready} !== 2'b11) begin
            n_errors++;
            $display("FAIL prio_write_after_r: aw/w=%b want 11", {bus.awready, bus.wready});
        end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        model_write(32'h30, wd, 4'hF);
        wait_b(r, to);
        n_checks++;
        if (to || r !== 2'b00) begin n_errors++; $display("FAIL prio_bresp: got %b want 00", r); end
        do_read(32'h30, d, r, lat, to);
        n_checks++;
        if (to || d !== wd) begin n_errors++; $display("FAIL prio_readback: got %h want %h", d, wd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0; logic [1:0] r; int lat; bit t1, t2;
        send_ar(32'h20, t1);
        wait_r(d0, r, lat, t2);
        n_checks++;
        if (t1 || t2 || d0 !== model_read(32'h20)) begin n_errors++; $display("FAIL bp_data: got %h want %h", d0, model_read(32'h20)); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.rvalid, bus.arready} !== 2'b10 || bus.rdata !== d0) begin
                n_errors++;
                $display("FAIL bp_hold_c%0d: rvalid=%b arready=%b rdata=%h want 1 0 %h", k, bus.rvalid, bus.arready, bus.rdata, d0);
            end
        end
        take_r();
        n_checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL bp_release: rvalid=%b rdata=%h want 0 0", bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_range();
        logic [31:0] d; logic [1:0] r; int lat; bit to;
        do_write(32'h0, 32'hA5A5_0001, 4'hF, r, to); model_write(32'h0, 32'hA5A5_0001, 4'hF);
        do_write(32'h4, 32'h5A5A_0002, 4'hF, r, to); model_write(32'h4, 32'h5A5A_0002, 4'hF);
        do_read(32'h4000, d, r, lat, to);
        n_checks++;
        if (to || d !== model_read(32'h4000) || r !== model_resp(32'h4000)) begin
            n_errors++;
            $display("FAIL range_read: got %h/%b want %h/%b", d, r, model_read(32'h4000), model_resp(32'h4000));
        end
        n_checks++;
        if (lat !== LAT + 1) begin n_errors++; $display("FAIL range_latency: got %0d want %0d", lat, LAT + 1); end
        do_write(32'h4004, 32'hC0DE_0003, 4'hF, r, to);
        model_write(32'h4004, 32'hC0DE_0003, 4'hF);
        n_checks++;
        if (to || r !== model_resp(32'h4004)) begin n_errors++; $display("FAIL range_bresp: got %b want %b", r, model_resp(32'h4004)); end
        do_read(32'h4, d, r, lat, to);
        n_checks++;
        if (to || d !== model_read(32'h4)) begin n_errors++; $display("FAIL range_write_effect: got %h want %h", d, model_read(32'h4)); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, got; logic [3:0] s; logic [1:0] r; int lat; bit to;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            do_write(BASE + 32'(4 * w), d, 4'hF, r, to);
            model_write(BASE + 32'(4 * w), d, 4'hF);
        end
        for (int k = 0; k < 40; k++) begin
            a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + 32'(4 * DEPTH);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, r, to);
                model_write(a, d, s);
                n_checks++;
                if (to || r !== model_resp(a)) begin n_errors++; $display("FAIL rnd_wr_%0d: a=%h resp %b want %b", k, a, r, model_resp(a)); end
            end else begin
                do_read(a, got, r, lat, to);
                n_checks++;
                if (to || got !== model_read(a) || r !== model_resp(a) || lat !== LAT + 1) begin
                    n_errors++;
                    $display("FAIL rnd_rd_%0d: a=%h got %h/%b lat %0d want %h/%b lat %0d",
                             k, a, got, r, lat, model_read(a), model_resp(a), LAT + 1);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic [1:0] r; int lat, seen; bit to;
        send_ar(32'h10, to);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.rvalid) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 0) begin n_errors++; $display("FAIL abort_no_resp: rvalid cycles=%0d want 0", seen); end
        n_checks++;
        if (bus.arready !== 1'b1) begin n_errors++; $display("FAIL abort_idle: arready=%b want 1", bus.arready); end
        do_read(32'h10, d, r, lat, to);
        n_checks++;
        if (to || d !== model_read(32'h10)) begin n_errors++; $display("FAIL abort_reread: got %h want %h", d, model_read(32'h10)); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_split_aw_w();
        test_ar_priority();
        test_backpressure();
        test_range();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram_slave.md
Name: axi_lite_ram_slave

Overview:
AXI-lite slave that terminates the arbiter's single master port, backed by a word-addressed on-chip RAM shared by instruction fetch and load/store.
- Serves one transaction at a time (read or write), with a programmable wait-state count.
- Gives the bus a deterministic, stallable target for pipeline bring-up and arbiter verification.

Parameters:
DEPTH, 4096, number of 32-bit RAM words; must be a power of two.
BASE_ADDR, 32'h0000_0000, byte address of word 0.
LATENCY, 1, wait cycles between address/data capture and response valid; range 0..15.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
bus  axi_lite_if.slave  -  AXI-lite slave port. Signals: araddr/awaddr 32, arvalid/arready, rdata 32, rresp 2, rvalid/rready, awvalid/awready, wdata 32, wstrb 4, wvalid/wready, bresp 2, bvalid/bready.

Behaviour:
- Reset: clk, rst_n is synchronous and active-low. On reset all outputs (arready, rvalid, awready, wready, bvalid) are 0, rdata is 0 and rresp/bresp are 0. RAM contents are not reset.
- Reset mid-transaction aborts it: no response is issued and the FSM returns to IDLE.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP.
- IDLE:
  - arready=1, awready=1, wready=1.
  - arvalid has priority. If arvalid is high, capture araddr, drop all readies and go to RD_WAIT. AW/W in the same cycle are not accepted (their readies are forced to 0).
  - Otherwise capture AW and/or W independently when each is valid. If both are captured, go to WR_WAIT; if only one, go to WR_COLLECT.
- WR_COLLECT: keep only the missing channel's ready high. Once it is captured, go to WR_WAIT. AR is not accepted here.
- RD_WAIT / WR_WAIT:
  - A 4-bit counter loads LATENCY on entry and decrements each cycle; exit when it reaches 0.
  - LATENCY=0 means the wait state lasts exactly one cycle (RAM read/write edge).
  - Read latency from AR handshake to rvalid is LATENCY+1 cycles.
- Memory update: the write happens on the WR_WAIT exit edge, per byte lane where wstrb[i]=1. wstrb=0 is a legal no-op that still returns OKAY.
- RD_RESP / WR_RESP:
  - rvalid (or bvalid) is held high with rdata/rresp (or bresp) stable until rready (or bready).
  - On the handshake, return to IDLE; the next request can be accepted the following cycle.
  - rdata returns to 0 after the handshake.
- Addressing:
  - word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits, so out-of-range addresses wrap.
  - addr[1:0] is ignored; no unaligned support.
- Responses are always OKAY (2'b00) unless AXI_RAM_ERR_EN is defined.
- A read issued after a write's B handshake returns the new data; there is no write buffering.

Optional Feature:
AXI_RAM_ERR_EN:
- Defined: an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH) gets SLVERR (2'b10). Reads return rdata=0. Writes leave memory unmodified. Timing is identical to the in-range case.
- Undefined: no range check; the address wraps and the response is OKAY.

Decomposition:
- Shared package axi_lite_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - ADDR_W=32, DATA_W=32, STRB_W=4.
- The FSM state enum stays local to the module.
- Sub-module ram_1rw: single-port, byte-enable synchronous RAM (clk, en, we[3:0], addr, wdata, rdata). It has a registered read; LATENCY counting accounts for its one-cycle read.

Test Plan:
- Write then read: write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF; then read 0x10. Required: bresp=0; rdata=0xDEADBEEF, rresp=0; rvalid exactly LATENCY+1 cycles after the AR handshake.
- Partial strobe: preload 0x11223344 at 0x20; write 0xAABBCCDD with wstrb=4'b0101. Required: read of 0x20 returns 0x11BB33DD.
- Split AW/W: wvalid asserted 3 cycles before awvalid. Required: wready drops after W capture; awready stays high; a single B response.
- Simultaneous arvalid and awvalid/wvalid in IDLE: read completes first with awready=0 throughout; write is accepted in the cycle after the R handshake.
- Backpressure: rready held 0 for 5 cycles. Required: rvalid and rdata stable for all 5 cycles; no new arready until the handshake.
- Range check: with AXI_RAM_ERR_EN and DEPTH=4096, read 0x4000. Required: rresp=2'b10, rdata=0. Without the macro: returns the word at 0x0000, rresp=0.
